bcd_timer_ctrl: RTL and testbench



---
 rtl/bcd_timer_ctrl.sv | 163 ++++++++++++++++
 tb/tb_bcd_timer_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_timer_ctrl.sv
// bcd_timer_ctrl: sequences a chain of single-digit BCD up/down counters as a
// programmable countdown timer. A preload steps every digit up to the target,
// then a prescaled tick decrements the chain with borrow propagation until the
// readback reaches zero.
//
// Strobe protocol with the counter chain: a strobe (dig_up, dig_down or
// dig_clr) is a one-cycle pulse; the chain applies it on the clock edge that
// ends the pulse, so count_in is stale while the pulse is visible. r_settle
// marks exactly those cycles, and count_in is never acted upon while it is set.
module bcd_timer_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  input  logic [4*NUM_DIGITS-1:0] count_in,
  output logic [NUM_DIGITS-1:0]   dig_up,
  output logic [NUM_DIGITS-1:0]   dig_down,
  output logic                    dig_clr,
  output logic [2:0]              state,
  output logic                    done
);

  localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                  r_state;
  logic [NUM_DIGITS-1:0]   r_dig_up;
  logic [NUM_DIGITS-1:0]   r_dig_down;
  logic                    r_dig_clr;
  logic                    r_done;
  logic                    r_settle;
  logic [PW-1:0]           r_presc;
  logic [4*NUM_DIGITS-1:0] r_target;

  logic [4*NUM_DIGITS-1:0] w_clamped;
  logic [NUM_DIGITS-1:0]   w_mismatch;
  logic [NUM_DIGITS-1:0]   w_borrow;
  logic                    w_count_zero;
  logic                    w_tick;
  logic [PW-1:0]           w_presc_next;

  // Clamp the preload digits, find digits still short of the target, and
  // build the borrow chain (digit i borrows when every lower digit is 0).
  always_comb begin
    logic v_low_zero;
    w_clamped  = '0;
    w_mismatch = '0;
    w_borrow   = '0;
    v_low_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_clamped[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
      w_mismatch[i]       = (count_in[4*i +: 4] != r_target[4*i +: 4]);
      w_borrow[i]         = v_low_zero;
      v_low_zero          = v_low_zero && (count_in[4*i +: 4] == 4'd0);
    end
  end

  assign w_count_zero = (count_in == '0);
  assign w_tick       = (r_presc == PRESC_LAST);
  assign w_presc_next = w_tick ? '0 : r_presc + PW'(1);

  // Main controller: command decode, preload stepping, countdown and outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_dig_up   <= '0;
      r_dig_down <= '0;
      r_dig_clr  <= 1'b0;
      r_done     <= 1'b0;
      r_settle   <= 1'b0;
      r_presc    <= '0;
      r_target   <= '0;
    end else begin
      // Strobes and done are single-cycle; settle follows whatever is issued.
      r_dig_up   <= '0;
      r_dig_down <= '0;
      r_dig_clr  <= 1'b0;
      r_done     <= 1'b0;
      r_settle   <= 1'b0;
      if (clear) begin
        r_dig_clr <= 1'b1;
        r_settle  <= 1'b1;
        r_presc   <= '0;
        r_state   <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (load) begin
              r_target <= w_clamped;
              r_state  <= ST_LOAD;
            end else if (start && !r_settle && !w_count_zero) begin
              r_presc <= '0;
              r_state <= ST_RUN;
            end
          end
          ST_LOAD: begin
            // Issue cycle when settle is clear; the following cycle is idle.
            if (!r_settle) begin
              if (|w_mismatch) begin
                r_dig_up <= w_mismatch;
                r_settle <= 1'b1;
              end else begin
                r_state <= ST_IDLE;
              end
            end
          end
          ST_RUN: begin
            if (pause) begin
              r_state <= ST_PAUSE;
            end else begin
              r_presc <= w_presc_next;
              if (!r_settle) begin
                if (w_count_zero) begin
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
                end else if (w_tick) begin
                  r_dig_down <= w_borrow;
                  r_settle   <= 1'b1;
                end
              end
            end
          end
          ST_PAUSE: begin
            if (load) begin
              r_target <= w_clamped;
              r_state  <= ST_LOAD;
            end else if (!pause && start) begin
              r_state <= ST_RUN;
            end
          end
          ST_DONE: begin
            if (load) begin
              r_target <= w_clamped;
              r_state  <= ST_LOAD;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign dig_up   = r_dig_up;
  assign dig_down = r_dig_down;
  assign dig_clr  = r_dig_clr;
  assign done     = r_done;
  assign state    = r_state;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Bench for bcd_timer_ctrl: a behavioural BCD digit chain answers the strobes,
// and the timer value is tracked as a plain integer to predict borrow patterns,
// counts, tick spacing and preload step counts.
module tb_bcd_timer_ctrl;
  localparam int ND = 4;
  localparam int PS = 4;
  localparam int W  = 4 * ND;

  logic          clk = 1'b0;
  logic          reset, start, pause, clear, load;
  logic [W-1:0]  load_val, count_in;
  logic [ND-1:0] dig_up, dig_down;
  logic          dig_clr, done;
  logic [2:0]    state;

  bcd_timer_ctrl #(.NUM_DIGITS(ND), .PRESCALE(PS)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .clear(clear),
    .load(load), .load_val(load_val), .count_in(count_in),
    .dig_up(dig_up), .dig_down(dig_down), .dig_clr(dig_clr),
    .state(state), .done(done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- digit chain environment ----------------
  logic [W-1:0] env_digits;
  always @(posedge clk) begin
    if (reset || dig_clr) env_digits <= '0;
    else begin
      for (int i = 0; i < ND; i++) begin
        if (dig_up[i])
          env_digits[4*i +: 4] <= (env_digits[4*i +: 4] == 4'd9) ? 4'd0 : env_digits[4*i +: 4] + 4'd1;
        else if (dig_down[i])
          env_digits[4*i +: 4] <= (env_digits[4*i +: 4] == 4'd0) ? 4'd9 : env_digits[4*i +: 4] - 4'd1;
      end
    end
  end
  assign count_in = env_digits;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [ND-1:0] exp_q[$];
  int model_val;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    t = v;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd(input logic [W-1:0] b);
    int r, p;
    r = 0; p = 1;
    for (int i = 0; i < ND; i++) begin
      r = r + int'(b[4*i +: 4]) * p;
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] b);
    logic [W-1:0] r;
    for (int i = 0; i < ND; i++)
      r[4*i +: 4] = (b[4*i +: 4] > 4'd9) ? 4'd9 : b[4*i +: 4];
    return r;
  endfunction

  // Digit i steps down on a decrement of v exactly when v is a multiple of 10^i.
  function automatic logic [ND-1:0] exp_borrow(input int v);
    logic [ND-1:0] r;
    int p;
    p = 1;
    for (int i = 0; i < ND; i++) begin
      r[i] = ((v % p) == 0);
      p = p * 10;
    end
    return r;
  endfunction

  // Expect n ticks counting down from v.
  task automatic arm(input int v, input int n);
    model_val = v;
    exp_q.delete();
    for (int j = 0; j < n; j++) exp_q.push_back(exp_borrow(v - j));
  endtask

  // ---------------- monitor ----------------
  int up_cnt[ND];
  int tick_cnt = 0, last_tick_cyc = 0, prev_tick_cyc = 0, last_up_cyc = 0;
  int done_cnt = 0, done_cyc = 0, done_run = 0, done_width = 0;
  int clr_cnt = 0, clr_run = 0, clr_width = 0;

  initial for (int i = 0; i < ND; i++) up_cnt[i] = 0;

  always @(negedge clk) begin
    logic [ND-1:0] pat;
    if (!reset) begin
      if ((|dig_up) || (|dig_down) || dig_clr)
        check("strobe_excl", 32'((|dig_up) ? 1 : 0) + 32'((|dig_down) ? 1 : 0) + 32'(dig_clr ? 1 : 0), 1);
      for (int i = 0; i < ND; i++) if (dig_up[i]) up_cnt[i]++;
      if (|dig_up) last_up_cyc = cyc;
      if (|dig_down) begin
        tick_cnt++;
        prev_tick_cyc = last_tick_cyc;
        last_tick_cyc = cyc;
        if (exp_q.size() == 0) check("tick_unexpected", 32'(dig_down), 0);
        else begin
          pat = exp_q.pop_front();
          check("borrow", 32'(dig_down), 32'(pat));
          check("tick_value", 32'(count_in), 32'(to_bcd(model_val)));
          model_val--;
        end
      end
      if (done) begin
        done_run++;
        if (done_run == 1) begin done_cnt++; done_cyc = cyc; end
      end else if (done_run != 0) begin
        done_width = done_run; done_run = 0;
      end
      if (dig_clr) begin
        clr_run++;
        if (clr_run == 1) clr_cnt++;
      end else if (clr_run != 0) begin
        clr_width = clr_run; clr_run = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
    int k;
    k = 0;
    while (state !== st && k < budget) begin step(1); k++; end
    check(tag, 32'(state), 32'(st));
  endtask

  task automatic wait_ticks(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (tick_cnt < target && k < budget) begin step(1); k++; end
    check(tag, tick_cnt, target);
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (done_cnt < target && k < budget) begin step(1); k++; end
    check(tag, done_cnt, target);
  endtask

  task automatic pulse_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic do_load(input logic [W-1:0] val, input bit with_start, input string tag);
    logic [W-1:0] tgt, c0;
    int up0[ND];
    int idle_cyc, steps;
    tgt = clamp_bcd(val);
    c0  = env_digits;
    up0 = up_cnt;
    steps = 0;
    load = 1'b1; load_val = val; start = with_start;
    step(1);
    load = 1'b0; start = 1'b0;
    check($sformatf("%s_enter_load", tag), 32'(state), 1);
    wait_state(3'd0, 40, $sformatf("%s_back_idle", tag));
    idle_cyc = cyc;
    check($sformatf("%s_value", tag), 32'(count_in), 32'(tgt));
    for (int i = 0; i < ND; i++) begin
      check($sformatf("%s_steps_d%0d", tag, i), up_cnt[i] - up0[i],
            (int'(tgt[4*i +: 4]) - int'(c0[4*i +: 4]) + 10) % 10);
      steps += up_cnt[i] - up0[i];
    end
    if (steps > 0)
      check($sformatf("%s_idle_lat", tag), 32'((idle_cyc - last_up_cyc) <= 7), 1);
  endtask

  task automatic do_clear(input string tag);
    int c0;
    c0 = clr_cnt;
    clear = 1'b1; step(1); clear = 1'b0;
    step(3);
    exp_q.delete();
    check($sformatf("%s_clr_pulses", tag), clr_cnt - c0, 1);
    check($sformatf("%s_clr_width", tag), clr_width, 1);
    check($sformatf("%s_state", tag), 32'(state), 0);
    check($sformatf("%s_digits", tag), 32'(count_in), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int t0, s, tk0, d0, up_sum, v, k, npause;
    logic [W-1:0] rv;

    reset = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0;
    step(3);
    check("rst_state", 32'(state), 0);
    check("rst_up", 32'(dig_up), 0);
    check("rst_down", 32'(dig_down), 0);
    check("rst_clr", 32'(dig_clr), 0);
    check("rst_done", 32'(done), 0);
    reset = 1'b0;
    step(1);

    // Preload 0123 from all-zero digits.
    do_load(16'h0123, 1'b0, "t1");

    // Borrow across two digits: 0100 -> 0099 -> 0098.
    do_load(16'h0100, 1'b0, "t2");
    arm(100, 2);
    t0 = cyc;
    pulse_start();
    check("t2_run", 32'(state), 2);
    tk0 = tick_cnt;
    wait_ticks(tk0 + 2, 30, "t2_ticks");
    check("t2_first_tick_lat", prev_tick_cyc - t0, PS + 1);
    check("t2_tick_period", last_tick_cyc - prev_tick_cyc, PS);
    step(2);
    check("t2_value", 32'(count_in), 32'(to_bcd(98)));
    check("t2_sb_drained", exp_q.size(), 0);
    do_clear("t2_clear");

    // Count 0002 to zero, done pulse, start ignored in DONE.
    do_load(16'h0002, 1'b0, "t3");
    arm(2, 2);
    d0 = done_cnt;
    pulse_start();
    wait_done(d0 + 1, 40, "t3_done_seen");
    step(2);
    check("t3_done_width", done_width, 1);
    check("t3_state_done", 32'(state), 4);
    check("t3_zero", 32'(count_in), 0);
    check("t3_done_after_tick", 32'((done_cyc - last_tick_cyc) >= 1 && (done_cyc - last_tick_cyc) <= 3), 1);
    tk0 = tick_cnt;
    pulse_start();
    step(3 * PS);
    check("t3_start_ignored", 32'(state), 4);
    check("t3_no_ticks", tick_cnt - tk0, 0);
    check("t3_single_done", done_cnt - d0, 1);

    // Pause with the prescaler at 2; reload from DONE first.
    v = $urandom_range(30, 99);
    do_load(to_bcd(v), 1'b0, "t4");
    arm(v, 2);
    pulse_start();
    tk0 = tick_cnt;
    wait_ticks(tk0 + 1, 20, "t4_first_tick");
    step((last_tick_cyc + 2) - cyc);
    pause = 1'b1;
    up_sum = 0;
    for (int i = 0; i < ND; i++) up_sum += up_cnt[i];
    npause = $urandom_range(8, 14);
    step(3);
    start = 1'b1; step(1); start = 1'b0;
    check("t4_pause_and_start", 32'(state), 3);
    step(npause - 4);
    check("t4_paused", 32'(state), 3);
    check("t4_no_ticks_paused", tick_cnt - (tk0 + 1), 0);
    for (int i = 0; i < ND; i++) up_sum -= up_cnt[i];
    check("t4_no_up_paused", up_sum, 0);
    pause = 1'b0;
    s = cyc;
    pulse_start();
    check("t4_resumed", 32'(state), 2);
    wait_ticks(tk0 + 2, 20, "t4_second_tick");
    check("t4_resume_lat", last_tick_cyc - s, 1 + (PS - 2));
    step(1);
    check("t4_value", 32'(count_in), 32'(to_bcd(v - 2)));
    do_clear("t4_clear");

    // Clear in the middle of a preload.
    load = 1'b1; load_val = 16'h0999; step(1); load = 1'b0;
    step(5);
    clear = 1'b1; step(1); clear = 1'b0;
    up_sum = 0;
    for (int i = 0; i < ND; i++) up_sum += up_cnt[i];
    step(8);
    for (int i = 0; i < ND; i++) up_sum -= up_cnt[i];
    check("t5_no_up_after_clear", up_sum, 0);
    check("t5_clr_width", clr_width, 1);
    check("t5_state", 32'(state), 0);
    check("t5_digits", 32'(count_in), 0);

    // Reset in the middle of a countdown.
    do_load(to_bcd(37), 1'b0, "t5r");
    arm(37, 1);
    pulse_start();
    tk0 = tick_cnt;
    wait_ticks(tk0 + 1, 20, "t5r_tick");
    reset = 1'b1; step(2);
    check("t5r_rst_down", 32'(dig_down), 0);
    check("t5r_rst_clr", 32'(dig_clr), 0);
    reset = 1'b0;
    exp_q.delete();
    step(2 * PS + 2);
    check("t5r_no_ticks", tick_cnt - (tk0 + 1), 0);
    check("t5r_state", 32'(state), 0);
    check("t5r_digits", 32'(count_in), 0);

    // Clamping, and load beats start in the same cycle.
    do_load(16'hA05F, 1'b1, "t6");

    // Randomized preload / countdown rounds.
    for (int it = 0; it < 6; it++) begin
      for (int d = 0; d < ND; d++) begin
        case ($urandom_range(0, 3))
          0: rv[4*d +: 4] = 4'd0;
          1: rv[4*d +: 4] = 4'd1;
          2: rv[4*d +: 4] = 4'd9;
          default: rv[4*d +: 4] = 4'($urandom_range(0, 15));
        endcase
      end
      if (it % 2 == 0) rv[4*(ND-1) +: 4] = 4'd0;
      if (it == 5) rv = '0;
      do_load(rv, 1'b0, $sformatf("rnd%0d", it));
      v = from_bcd(clamp_bcd(rv));
      k = $urandom_range(1, 5);
      if (v == 0) begin
        pulse_start();
        step(3);
        check("rnd_zero_start_ignored", 32'(state), 0);
      end else if (v <= k) begin
        arm(v, v);
        d0 = done_cnt;
        pulse_start();
        wait_done(d0 + 1, v * PS + 20, "rnd_done_seen");
        step(2);
        check("rnd_done_state", 32'(state), 4);
        check("rnd_done_zero", 32'(count_in), 0);
        do_clear("rnd_clear_a");
      end else begin
        arm(v, k);
        tk0 = tick_cnt;
        pulse_start();
        load = 1'b1; load_val = W'($urandom); step(1); load = 1'b0;
        check("rnd_load_ignored_in_run", 32'(state), 2);
        wait_ticks(tk0 + k, k * PS + 20, "rnd_ticks");
        step(2);
        check("rnd_value", 32'(count_in), 32'(to_bcd(v - k)));
        check("rnd_sb_drained", exp_q.size(), 0);
        do_clear("rnd_clear_b");
      end
    end

    check("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
